// File: rtl/multu_hilo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multu_hilo_ctrl: HI/LO issue/writeback stage for a multicycle MULTU unit |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multu_hilo_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    output logic               op_ready,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               mult_start,
    output logic               mult_clr,
    input  logic [2*WIDTH-1:0] mult_prod,
    input  logic               mult_done,
    output logic               busy,
    output logic               err
);

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MFHI  = 3'b010;
    localparam logic [2:0] OP_MFLO  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic              accept;
    logic              done_hit;
    logic              timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion beats the watchdog when both land in the same cycle.
    always_comb begin
        state_nxt   = state;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && (op == OP_MULTU)) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = BUSY;
            end
            BUSY: begin
                if (mult_done) begin
                    done_hit  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign op_ready   = (state == IDLE);
    assign accept     = op_valid && op_ready;
    assign mult_start = (state == START);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            mult_clr <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            rd_valid <= 1'b0;
            mult_clr <= timeout_hit;
            if (timeout_hit) begin
                err <= 1'b1;
            end

            if (state == START) begin
                cnt <= '0;
            end else if ((state == BUSY) && !mult_done) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (done_hit) begin
                {hi, lo} <= mult_prod;
            end

            // Ops are only accepted in IDLE, so they never collide with done_hit.
            if (accept) begin
                case (op)
                    OP_MULTU: begin
                        mult_a <= rs_val;
                        mult_b <= rt_val;
                    end
                    OP_MFHI: begin
                        rd_data  <= hi;
                        rd_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        rd_data  <= lo;
                        rd_valid <= 1'b1;
                    end
                    OP_MTHI: begin
                        hi <= rs_val;
                    end
                    OP_MTLO: begin
                        lo <= rs_val;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multu_hilo_ctrl.sv
`default_nettype none
// Directed and randomized bench for multu_hilo_ctrl with a behavioural
// multiplier and a HI/LO reference model.
module tb_multu_hilo_ctrl;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] MFHI  = 3'b010;
    localparam logic [2:0] MFLO  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic               clk = 1'b0;
    logic               reset;
    logic               op_valid;
    logic [2:0]         op;
    logic [WIDTH-1:0]   rs_val;
    logic [WIDTH-1:0]   rt_val;
    logic               op_ready;
    logic               rd_valid;
    logic [WIDTH-1:0]   rd_data;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_start;
    logic               mult_clr;
    logic [2*WIDTH-1:0] mult_prod = '0;
    logic               mult_done = 1'b0;
    logic               busy;
    logic               err;

    int checks = 0;
    int errors = 0;

    // Multiplier model controls
    int   lat        = 5;
    bit   responds   = 1'b1;
    bit   force_done = 1'b0;
    bit   armed      = 1'b0;
    int   remaining  = 0;

    logic [WIDTH-1:0] ref_hi = '0;
    logic [WIDTH-1:0] ref_lo = '0;

    multu_hilo_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .op_ready   (op_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_start (mult_start),
        .mult_clr   (mult_clr),
        .mult_prod  (mult_prod),
        .mult_done  (mult_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: done arrives 'lat' cycles after the start cycle,
    // ignores reset, and is cancelled only by mult_clr.
    always @(negedge clk) begin
        mult_done = 1'b0;
        if (force_done) begin
            mult_done = 1'b1;
            mult_prod = 64'hA5A5_5A5A_0F0F_F0F0;
        end else if (mult_clr) begin
            armed = 1'b0;
        end else if (mult_start) begin
            armed     = 1'b1;
            remaining = lat;
        end else if (armed) begin
            remaining--;
            if (remaining == 0) begin
                armed = 1'b0;
                if (responds) begin
                    mult_done = 1'b1;
                    mult_prod = 64'(mult_a) * 64'(mult_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents an op, waits (bounded) for op_ready, returns 1ns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        while (!op_ready && n < 200) begin
            tick();
            n++;
        end
        if (!op_ready) check("issue_stall", 64'(op_ready), 64'(1));
        tick();
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic run_busy(output int busyc, output int starts, output int clrs);
        int n;
        n      = 0;
        busyc  = 0;
        starts = 0;
        clrs   = 0;
        while (busy && n < 300) begin
            busyc++;
            if (mult_start) starts++;
            if (mult_clr) clrs++;
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            if (mult_clr) clrs++;
            tick();
        end
    endtask

    task automatic read_check(input string tag, input logic [2:0] o, input logic [31:0] exp);
        issue(o, $urandom, $urandom);
        check({tag, "_valid"}, 64'(rd_valid), 64'(1));
        check({tag, "_data"}, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        int busyc, starts, clrs;
        logic [31:0] a, b;
        logic [63:0] p;
        int r;

        reset    = 1'b0;
        op_valid = 1'b0;
        op       = NOP;
        rs_val   = '0;
        rt_val   = '0;

        // Reset with random inputs
        for (int k = 0; k < 4; k++) begin
            op_valid = 1'($urandom);
            op       = 3'($urandom);
            rs_val   = $urandom;
            rt_val   = $urandom;
            tick();
        end
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_mult_a", 64'(mult_a), 64'(0));
        check("rst_mult_b", 64'(mult_b), 64'(0));
        check("rst_mult_start", 64'(mult_start), 64'(0));
        check("rst_mult_clr", 64'(mult_clr), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        op_valid = 1'b0;
        op       = NOP;
        reset    = 1'b1;
        tick();
        check("rst_op_ready", 64'(op_ready), 64'(1));
        read_check("rst_mfhi", MFHI, 32'h0);

        // Max-operand multiply
        lat = 33;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_start", 64'(mult_start), 64'(1));
        check("max_mult_a", 64'(mult_a), 64'hFFFF_FFFF);
        check("max_mult_b", 64'(mult_b), 64'hFFFF_FFFF);
        run_busy(busyc, starts, clrs);
        check("max_busy_span", 64'(busyc), 64'(lat + 1));
        check("max_start_pulses", 64'(starts), 64'(1));
        check("max_op_ready", 64'(op_ready), 64'(1));
        read_check("max_mfhi", MFHI, 32'hFFFF_FFFE);
        read_check("max_mflo", MFLO, 32'h0000_0001);
        tick();
        check("max_rd_valid_drop", 64'(rd_valid), 64'(0));
        ref_hi = 32'hFFFF_FFFE;
        ref_lo = 32'h0000_0001;

        // MFLO stalled behind a MULTU
        lat = 20;
        a = $urandom;
        b = $urandom;
        p = 64'(a) * 64'(b);
        issue(MULTU, a, b);
        check("stall_op_ready", 64'(op_ready), 64'(0));
        issue(MFLO, 32'h0, 32'h0);
        check("stall_mflo_valid", 64'(rd_valid), 64'(1));
        check("stall_mflo_data", 64'(rd_data), 64'(p[31:0]));
        tick();
        check("stall_mflo_once", 64'(rd_valid), 64'(0));
        ref_hi = p[63:32];
        ref_lo = p[31:0];

        // Back-to-back moves
        issue(MTHI, 32'h1234_5678, 32'h0);
        issue(MTLO, 32'h9ABC_DEF0, 32'h0);
        issue(MFHI, 32'h0, 32'h0);
        check("b2b_mfhi", 64'(rd_data), 64'h1234_5678);
        issue(MFLO, 32'h0, 32'h0);
        check("b2b_mflo", 64'(rd_data), 64'h9ABC_DEF0);
        check("b2b_mflo_valid", 64'(rd_valid), 64'(1));
        ref_hi = 32'h1234_5678;
        ref_lo = 32'h9ABC_DEF0;

        // Stray done while idle is ignored
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        read_check("stray_mfhi", MFHI, ref_hi);
        read_check("stray_mflo", MFLO, ref_lo);

        // Done lands in the same cycle as the watchdog limit
        lat = TIMEOUT;
        a = $urandom;
        b = $urandom;
        p = 64'(a) * 64'(b);
        issue(MULTU, a, b);
        run_busy(busyc, starts, clrs);
        check("edge_busy_span", 64'(busyc), 64'(TIMEOUT + 1));
        check("edge_err", 64'(err), 64'(0));
        check("edge_clr_pulses", 64'(clrs), 64'(0));
        ref_hi = p[63:32];
        ref_lo = p[31:0];
        read_check("edge_mfhi", MFHI, ref_hi);
        read_check("edge_mflo", MFLO, ref_lo);

        // Watchdog timeout
        responds = 1'b0;
        lat = 10;
        issue(MULTU, $urandom, $urandom);
        run_busy(busyc, starts, clrs);
        check("to_busy_span", 64'(busyc), 64'(TIMEOUT + 1));
        check("to_err", 64'(err), 64'(1));
        check("to_clr_pulses", 64'(clrs), 64'(1));
        check("to_op_ready", 64'(op_ready), 64'(1));
        read_check("to_mfhi", MFHI, ref_hi);
        read_check("to_mflo", MFLO, ref_lo);
        responds = 1'b1;
        issue(MULTU, 32'd3, 32'd5);
        run_busy(busyc, starts, clrs);
        read_check("to_after_mflo", MFLO, 32'd15);
        read_check("to_after_mfhi", MFHI, 32'd0);
        check("to_err_sticky", 64'(err), 64'(1));

        // Reset mid-multiply; the late done must not land
        lat = 33;
        issue(MULTU, $urandom | 32'h1, $urandom | 32'h1);
        repeat (10) tick();
        check("mid_busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_op_ready", 64'(op_ready), 64'(1));
        tick();
        tick();
        reset = 1'b1;
        repeat (30) tick();
        check("mid_err", 64'(err), 64'(0));
        read_check("mid_mfhi", MFHI, 32'h0);
        read_check("mid_mflo", MFLO, 32'h0);
        ref_hi = '0;
        ref_lo = '0;

        // Randomized op stream against the reference model
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            case (r)
                0: begin
                    lat = int'($urandom_range(1, TIMEOUT - 2));
                    issue(MULTU, a, b);
                    p = 64'(a) * 64'(b);
                    ref_hi = p[63:32];
                    ref_lo = p[31:0];
                end
                1: begin
                    issue(MTHI, a, b);
                    ref_hi = a;
                end
                2: begin
                    issue(MTLO, a, b);
                    ref_lo = a;
                end
                3: read_check("rnd_mfhi", MFHI, ref_hi);
                4: read_check("rnd_mflo", MFLO, ref_lo);
                default: begin
                    issue(3'($urandom_range(6, 7)), a, b);
                    check("rnd_nop_busy", 64'(busy), 64'(0));
                    check("rnd_nop_rd_valid", 64'(rd_valid), 64'(0));
                end
            endcase
        end
        read_check("final_mfhi", MFHI, ref_hi);
        read_check("final_mflo", MFLO, ref_lo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multu_hilo_ctrl.md
Name: multu_hilo_ctrl

Overview:
- Issue/writeback stage directly upstream of the multi-cycle unsigned multiplier.
- Accepts HI/LO-class ops from the decode stage: MULTU, MFHI, MFLO, MTHI, MTLO.
- For MULTU, holds operands stable, pulses the multiplier start, waits for its done, and captures the 64-bit product into HI/LO.
- Stalls the pipeline while a multiply is in flight; a watchdog recovers if done never arrives.

Parameters:
- WIDTH, 32, operand/HI/LO width; product is 2*WIDTH.
- TIMEOUT, 40, max BUSY cycles before abort; must exceed multiplier latency (WIDTH+2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  op present on op/rs_val/rt_val.
- op  in  3  000 NOP, 001 MULTU, 010 MFHI, 011 MFLO, 100 MTHI, 101 MTLO, 11x NOP.
- rs_val  in  WIDTH  multiplicand / MTHI/MTLO source.
- rt_val  in  WIDTH  multiplier operand.
- op_ready  out  1  op accepted this cycle when op_valid & op_ready.
- rd_valid  out  1  one-cycle pulse: rd_data holds an MFHI/MFLO result.
- rd_data  out  WIDTH  move-from result.
- mult_a  out  WIDTH  latched multiplicand to multiplier.
- mult_b  out  WIDTH  latched multiplier to multiplier.
- mult_start  out  1  one-cycle start pulse to multiplier.
- mult_clr  out  1  one-cycle abort/clear pulse to multiplier.
- mult_prod  in  2*WIDTH  multiplier product, valid while mult_done=1.
- mult_done  in  1  multiplier completion.
- busy  out  1  multiply in flight (state != IDLE).
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset=0): state IDLE; HI, LO, mult_a, mult_b, rd_data = 0; rd_valid, mult_start, mult_clr, err = 0; cycle counter = 0. Reset asserted mid-multiply aborts immediately. HI/LO are not written.
- States:
  - IDLE: op_ready=1.
  - START: mult_start=1 for exactly one cycle.
  - BUSY: wait for mult_done.
- op_ready = 1 only in IDLE. Ops presented in START/BUSY are held off (stall); NOP never changes state.
- MULTU accepted in IDLE: next edge latches mult_a<=rs_val, mult_b<=rt_val and enters START. mult_a/mult_b stay stable until the next MULTU is accepted.
- START -> BUSY unconditionally. Counter cleared on START.
- In BUSY, each cycle without mult_done increments the counter.
  - mult_done=1: HI<=mult_prod[2W-1:W], LO<=mult_prod[W-1:0]; -> IDLE.
  - Counter reaches TIMEOUT-1 with mult_done=0: err<=1, mult_clr=1 for one cycle, HI/LO unchanged; -> IDLE.
  - mult_done in the same cycle as the timeout: done wins, err stays 0.
- mult_done while in IDLE or START is ignored.
- MFHI/MFLO accepted: next cycle rd_valid=1 and rd_data=HI/LO (value at acceptance); otherwise rd_valid=0 and rd_data holds its last value.
- MTHI/MTLO accepted: HI/LO<=rs_val at the next edge. MFHI in the cycle immediately after MTHI returns the new value.
- Back-to-back accepted ops in consecutive IDLE cycles are legal.
- MULTU issue-to-IDLE latency = 2 + multiplier latency; busy is high for exactly that span minus one.
- err clears only on reset.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, op_ready=1 after release.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, model returns done after 33 cycles with prod 0xFFFFFFFE00000001. Required:
  - mult_start pulses once, 1 cycle after accept.
  - MFHI then returns 0xFFFFFFFE; MFLO returns 0x00000001.
- MFLO issued the cycle after MULTU accept -> op_ready=0 until done. Once accepted, rd_data = new LO; exactly one rd_valid pulse.
- MTHI 0x12345678, MTLO 0x9ABCDEF0 back-to-back, then MFHI, MFLO -> rd_data 0x12345678 then 0x9ABCDEF0 on consecutive cycles.
- Model never asserts done -> after TIMEOUT BUSY cycles err=1, one mult_clr pulse, HI/LO unchanged, op_ready=1. A following MULTU 3*5 returns LO=15, HI=0.
- Reset pulsed 10 cycles into BUSY -> state IDLE, HI/LO=0, busy=0. A late mult_done after release leaves HI/LO=0.
